// File: rtl/esm_pkg.sv
// Shared ESM types: per-entry scheduler state and index-width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package esm_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        WAIT   = 2'd1,
        READY  = 2'd2,
        ISSUED = 2'd3
    } entry_state_e;

    // Width of a buffer index for an n-entry buffer (at least 1 bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/esm_issue_scheduler_if.sv
// Handshake bundle between the ESM front end, the issue scheduler and execution.
// Latency: n/a (wires only).
// Backpressure: alloc_ready / issue_ready; completion has none.
// master = upstream/execution side, slave = scheduler side.
interface esm_issue_scheduler_if #(parameter int bs = 16);
    import esm_pkg::*;
    localparam int IDX_W = idx_w(bs);

    logic             flush;
    logic             alloc_valid;
    logic [bs-1:0]    alloc_dep;
    logic             alloc_ready;
    logic [IDX_W-1:0] alloc_index;
    logic             issue_valid;
    logic [IDX_W-1:0] issue_index;
    logic             issue_ready;
    logic             complete_valid;
    logic [IDX_W-1:0] complete_index;
    logic [IDX_W:0]   occupancy;

    modport master (
        output flush, alloc_valid, alloc_dep, issue_ready, complete_valid, complete_index,
        input  alloc_ready, alloc_index, issue_valid, issue_index, occupancy
    );

    modport slave (
        input  flush, alloc_valid, alloc_dep, issue_ready, complete_valid, complete_index,
        output alloc_ready, alloc_index, issue_valid, issue_index, occupancy
    );
endinterface

// File: rtl/esm_prio_enc.sv
// Lowest-set-bit encoder: index of the least significant set bit plus any-set flag.
// Latency: combinational.
// Backpressure: none.
// Ports: req_i (W bits), idx_o (0 when nothing set), vld_o.
module esm_prio_enc
    import esm_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0]         req_i,
    output logic [idx_w(W)-1:0]  idx_o,
    output logic                 vld_o
);
    localparam int IW = idx_w(W);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IW'(i);
        end
    end

    assign vld_o = |req_i;
endmodule

// File: rtl/esm_issue_scheduler.sv
// Out-of-order issue scheduler: tracks bs entries, dep matrix and age matrix; issues oldest READY.
// Latency: alloc visible to issue one cycle after the allocating edge; WAIT->READY one edge after deps clear.
// Backpressure: alloc_ready low when full (upstream holds); issue holds while issue_ready low.
// Ports: clk, rst_n (async active-low), bus (slave: flush, alloc_*, issue_*, complete_*, occupancy).
module esm_issue_scheduler
    import esm_pkg::*;
#(
    parameter int bs = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    esm_issue_scheduler_if.slave   bus
);
    localparam int IDX_W = idx_w(bs);
    localparam int OCC_W = IDX_W + 1;

    entry_state_e      state_q [bs];
    entry_state_e      state_d [bs];
    logic [bs-1:0]     dep_q   [bs];   // dep_q[i][j]: entry i waits on producer j
    logic [bs-1:0]     dep_d   [bs];
    logic [bs-1:0]     older_q [bs];   // older_q[i][j]: i allocated before j
    logic [bs-1:0]     older_d [bs];
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic [bs-1:0]     free_vec, ready_vec, issue_oh;
    logic [bs-1:0]     alloc_mask, cmpl_mask, alloc_eff;
    logic [IDX_W-1:0]  alloc_idx, issue_idx;
    logic              alloc_rdy, issue_vld;
    logic              alloc_fire, issue_fire, cmpl_fire;

    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < bs; i++) begin
            free_vec[i]  = (state_q[i] == FREE);
            ready_vec[i] = (state_q[i] == READY);
        end
    end

    // An entry is selected when no other READY entry is older than it.
    // Ages form a total order over live entries, so at most one bit is set.
    always_comb begin
        logic [bs-1:0] col;
        col      = '0;
        issue_oh = '0;
        for (int i = 0; i < bs; i++) begin
            for (int j = 0; j < bs; j++) col[j] = older_q[j][i];
            issue_oh[i] = ready_vec[i] & ~|(ready_vec & col);
        end
    end

    esm_prio_enc #(.W(bs)) u_alloc_enc (
        .req_i (free_vec),
        .idx_o (alloc_idx),
        .vld_o (alloc_rdy)
    );

    esm_prio_enc #(.W(bs)) u_issue_enc (
        .req_i (issue_oh),
        .idx_o (issue_idx),
        .vld_o (issue_vld)
    );

    assign alloc_fire = bus.alloc_valid & alloc_rdy;
    assign issue_fire = issue_vld & bus.issue_ready;
    assign cmpl_fire  = bus.complete_valid & (state_q[bus.complete_index] == ISSUED);
    assign alloc_mask = bs'(1) << alloc_idx;
    assign cmpl_mask  = cmpl_fire ? (bs'(1) << bus.complete_index) : '0;

    // Only live producers count; a producer completing on this edge is already satisfied.
    assign alloc_eff = bus.alloc_dep & ~free_vec & ~alloc_mask & ~cmpl_mask;

    always_comb begin
        for (int i = 0; i < bs; i++) begin
            state_d[i] = state_q[i];
            dep_d[i]   = dep_q[i];
            older_d[i] = older_q[i];
        end
        occ_d = occ_q;

        if (bus.flush) begin
            for (int i = 0; i < bs; i++) begin
                state_d[i] = FREE;
                dep_d[i]   = '0;
                older_d[i] = '0;
            end
            occ_d = '0;
        end else begin
            for (int i = 0; i < bs; i++) begin
                // Promotion looks at the registered row, so it trails the clearing edge by one.
                if (state_q[i] == WAIT && dep_q[i] == '0) state_d[i] = READY;
                dep_d[i]   = dep_q[i] & ~cmpl_mask;
                older_d[i] = older_q[i] & ~cmpl_mask;
            end
            if (cmpl_fire) begin
                state_d[bus.complete_index] = FREE;
                older_d[bus.complete_index] = '0;
            end
            if (issue_fire) state_d[issue_idx] = ISSUED;
            if (alloc_fire) begin
                state_d[alloc_idx] = (alloc_eff != '0) ? WAIT : READY;
                dep_d[alloc_idx]   = alloc_eff;
                older_d[alloc_idx] = '0;
                for (int j = 0; j < bs; j++) begin
                    if (!free_vec[j] && !cmpl_mask[j]) older_d[j][alloc_idx] = 1'b1;
                end
            end
            occ_d = occ_q + OCC_W'(alloc_fire) - OCC_W'(cmpl_fire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < bs; i++) begin
                state_q[i] <= FREE;
                dep_q[i]   <= '0;
                older_q[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            for (int i = 0; i < bs; i++) begin
                state_q[i] <= state_d[i];
                dep_q[i]   <= dep_d[i];
                older_q[i] <= older_d[i];
            end
            occ_q <= occ_d;
        end
    end

    assign bus.alloc_ready = alloc_rdy;
    assign bus.alloc_index = alloc_idx;
    assign bus.issue_valid = issue_vld;
    assign bus.issue_index = issue_idx;
    assign bus.occupancy   = occ_q;
endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Directed bench for esm_issue_scheduler: vector table plus hand-written corner sequences.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: issue_ready driven per vector.
module tb_esm_issue_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    esm_issue_scheduler_if #(.bs(16)) bus ();

    esm_issue_scheduler #(.bs(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        fl;
        logic        av;
        logic [15:0] dep;
        logic        ir;
        logic        cv;
        logic [3:0]  ci;
        logic        e_ar;
        logic [3:0]  e_ai;
        logic        e_iv;
        logic [3:0]  e_ii;
        logic [4:0]  e_occ;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic av, input logic [15:0] dep,
                         input logic ir, input logic cv, input logic [3:0] ci);
        bus.flush          = fl;
        bus.alloc_valid    = av;
        bus.alloc_dep      = dep;
        bus.issue_ready    = ir;
        bus.complete_valid = cv;
        bus.complete_index = ci;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp_order [5];

    initial begin
        drive(0, 0, 16'h0, 0, 0, 4'd0);

        // Test 1: three independent allocs issue in order, then complete.
        vt[0]  = '{0, 1, 16'h0000, 1, 0, 4'd0, 1, 4'd1, 1, 4'd0, 5'd1};
        vt[1]  = '{0, 1, 16'h0000, 1, 0, 4'd0, 1, 4'd2, 1, 4'd1, 5'd2};
        vt[2]  = '{0, 1, 16'h0000, 1, 0, 4'd0, 1, 4'd3, 1, 4'd2, 5'd3};
        vt[3]  = '{0, 0, 16'h0000, 1, 0, 4'd0, 1, 4'd3, 0, 4'd0, 5'd3};
        vt[4]  = '{0, 0, 16'h0000, 1, 1, 4'd0, 1, 4'd0, 0, 4'd0, 5'd2};
        vt[5]  = '{0, 0, 16'h0000, 1, 1, 4'd1, 1, 4'd0, 0, 4'd0, 5'd1};
        vt[6]  = '{0, 0, 16'h0000, 1, 1, 4'd2, 1, 4'd0, 0, 4'd0, 5'd0};
        // Test 2: deps on free entries and self are masked; real dep waits for completion.
        vt[7]  = '{0, 1, 16'hFFFF, 0, 0, 4'd0, 1, 4'd1, 1, 4'd0, 5'd1};
        vt[8]  = '{0, 1, 16'h0001, 1, 0, 4'd0, 1, 4'd2, 0, 4'd0, 5'd2};
        vt[9]  = '{0, 0, 16'h0000, 1, 1, 4'd1, 1, 4'd2, 0, 4'd0, 5'd2};
        vt[10] = '{0, 0, 16'h0000, 1, 1, 4'd0, 1, 4'd0, 0, 4'd0, 5'd1};
        vt[11] = '{0, 0, 16'h0000, 1, 0, 4'd0, 1, 4'd0, 1, 4'd1, 5'd1};
        vt[12] = '{0, 0, 16'h0000, 1, 0, 4'd0, 1, 4'd0, 0, 4'd0, 5'd1};
        vt[13] = '{0, 0, 16'h0000, 1, 1, 4'd1, 1, 4'd0, 0, 4'd0, 5'd0};

        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2;
        exp_order[3] = 4; exp_order[4] = 5;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("reset_alloc_ready", 32'(bus.alloc_ready), 32'd1);
        chk("reset_alloc_index", 32'(bus.alloc_index), 32'd0);
        chk("reset_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("reset_issue_index", 32'(bus.issue_index), 32'd0);
        chk("reset_occupancy",   32'(bus.occupancy),   32'd0);

        for (int v = 0; v < 14; v++) begin
            drive(vt[v].fl, vt[v].av, vt[v].dep, vt[v].ir, vt[v].cv, vt[v].ci);
            step();
            chk($sformatf("v%0d_alloc_ready", v), 32'(bus.alloc_ready), 32'(vt[v].e_ar));
            chk($sformatf("v%0d_alloc_index", v), 32'(bus.alloc_index), 32'(vt[v].e_ai));
            chk($sformatf("v%0d_issue_valid", v), 32'(bus.issue_valid), 32'(vt[v].e_iv));
            if (vt[v].e_iv)
                chk($sformatf("v%0d_issue_index", v), 32'(bus.issue_index), 32'(vt[v].e_ii));
            chk($sformatf("v%0d_occupancy", v), 32'(bus.occupancy), 32'(vt[v].e_occ));
        end

        // Test 3: fill all 16 entries with issue held off.
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fill%0d_alloc_index", i), 32'(bus.alloc_index), 32'(i));
            drive(0, 1, 16'h0, 0, 0, 4'd0);
            step();
        end
        chk("full_alloc_ready", 32'(bus.alloc_ready), 32'd0);
        chk("full_alloc_index", 32'(bus.alloc_index), 32'd0);
        chk("full_occupancy",   32'(bus.occupancy),   32'd16);
        chk("full_issue_index", 32'(bus.issue_index), 32'd0);
        step();
        step();
        chk("full_ignored_occupancy", 32'(bus.occupancy), 32'd16);

        // Flush from full, with a competing alloc on the same edge.
        drive(1, 1, 16'h0, 1, 0, 4'd0);
        step();
        drive(0, 0, 16'h0, 0, 0, 4'd0);
        chk("flush_occupancy",   32'(bus.occupancy),   32'd0);
        chk("flush_alloc_ready", 32'(bus.alloc_ready), 32'd1);
        chk("flush_issue_valid", 32'(bus.issue_valid), 32'd0);

        // Tests 4/5: entry 3 waits on 2; issue the rest oldest-first.
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, (i == 3) ? 16'h0004 : 16'h0000, 0, 0, 4'd0);
            step();
        end
        chk("six_occupancy", 32'(bus.occupancy), 32'd6);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("order%0d_issue_valid", k), 32'(bus.issue_valid), 32'd1);
            chk($sformatf("order%0d_issue_index", k), 32'(bus.issue_index), 32'(exp_order[k]));
            drive(0, 0, 16'h0, 1, 0, 4'd0);
            step();
        end
        chk("wait3_issue_valid", 32'(bus.issue_valid), 32'd0);
        drive(0, 0, 16'h0, 0, 1, 4'd5);
        step();
        chk("reuse_alloc_index", 32'(bus.alloc_index), 32'd5);
        chk("reuse_occupancy",   32'(bus.occupancy),   32'd5);
        // Same edge: complete 2 and alloc entry 5 depending on 2.
        drive(0, 1, 16'h0004, 0, 1, 4'd2);
        step();
        drive(0, 0, 16'h0, 0, 0, 4'd0);
        chk("same_edge_issue_valid", 32'(bus.issue_valid), 32'd1);
        chk("same_edge_issue_index", 32'(bus.issue_index), 32'd5);
        chk("same_edge_alloc_index", 32'(bus.alloc_index), 32'd2);
        chk("same_edge_occupancy",   32'(bus.occupancy),   32'd5);
        step();
        chk("age_issue_index", 32'(bus.issue_index), 32'd3);

        // Test 6: async reset with 7 occupied entries.
        drive(0, 1, 16'h0, 0, 0, 4'd0);
        step();
        chk("grow_alloc_index", 32'(bus.alloc_index), 32'd6);
        step();
        drive(0, 0, 16'h0, 0, 0, 4'd0);
        chk("seven_occupancy", 32'(bus.occupancy), 32'd7);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
        chk("arst_alloc_index", 32'(bus.alloc_index), 32'd0);
        chk("arst_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("arst_issue_index", 32'(bus.issue_index), 32'd0);
        chk("arst_occupancy",   32'(bus.occupancy),   32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_arst_occupancy", 32'(bus.occupancy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/esm_issue_scheduler.md
Name: esm_issue_scheduler

Overview:
- Out-of-order issue scheduler for the ESM instruction buffer of bs entries.
- Accepts each decoded instruction together with its dependency row, which the dependency-analysis stage computes against in-flight buffer entries.
- Tracks per-entry state and a registered dependency matrix, and issues the oldest ready entry each cycle.
- Clears dependency columns on completion; supplies the free buffer index consumed by the dependency-analysis stage.

Parameters:
- bs, 16, number of buffer entries (power of 2, ≥2).
- IDX_W, $clog2(bs), width of a buffer index (derived localparam, not overridable).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all entries.
- alloc_valid  input  1  new instruction present.
- alloc_dep  input  bs  dependency row of new instruction; bit j = depends on entry j.
- alloc_ready  output  1  at least one FREE entry.
- alloc_index  output  IDX_W  lowest-numbered FREE entry; drives dependency-analysis buffer_index.
- issue_valid  output  1  at least one READY entry.
- issue_index  output  IDX_W  oldest READY entry.
- issue_ready  input  1  execution unit accepts issue.
- complete_valid  input  1  an issued instruction finished.
- complete_index  input  IDX_W  entry that finished.
- occupancy  output  IDX_W+1  number of non-FREE entries.

Behaviour:
- Per-entry 2-bit state: FREE, WAIT, READY, ISSUED. Registered dep matrix dep[i][j] (row = entry i, column = producer j). Age matrix older[i][j] = 1 when i was allocated before j.
- Reset (rst_n low, async): all entries FREE, dep and age matrices 0, occupancy 0. Outputs follow: alloc_ready 1, alloc_index 0, issue_valid 0, issue_index 0.
- Allocation fires when alloc_valid & alloc_ready at the rising edge, on entry a = alloc_index.
  - Effective row = alloc_dep masked by: bit a cleared; bits of FREE entries cleared; bit complete_index cleared if a completion fires on the same edge.
  - Entry enters WAIT if the effective row is nonzero, else READY.
  - Set older[j][a] = 1 for every non-FREE j (not completing this edge); clear row older[a][*].
- alloc_valid with alloc_ready = 0: ignored; no state change. The upstream stage holds.
- Eligibility: a WAIT entry whose registered dep row becomes all-zero transitions to READY on the next edge. Minimum latency from allocation edge to issue_valid is 0 cycles when the effective row is 0, with the entry visible the cycle after allocation.
- issue_index = the READY entry i with no READY j where older[j][i] = 1. Ties are impossible by construction.
- Issue handshake fires when issue_valid & issue_ready at the edge; entry issue_index goes READY → ISSUED. issue_valid/issue_index are combinational from registered state only, with no path from issue_ready.
- Completion fires when complete_valid and entry complete_index is ISSUED.
  - Entry → FREE.
  - Column complete_index cleared in every row.
  - older row and column for that entry cleared.
  - complete_valid on a non-ISSUED entry: ignored.
- Simultaneous events in one edge (all allowed):
  - alloc, issue and complete on distinct entries all take effect.
  - Completing entry's index may equal alloc_index on the next cycle only; alloc_index is computed from pre-edge state, so no same-edge reuse.
- occupancy = registered count: +1 on alloc, −1 on completion, net 0 when both occur.
- flush (sync, priority over alloc/issue/complete): same state as reset on the next edge.
- rst_n assertion mid-operation: immediate return to reset state; in-flight issues are lost.
- Full: occupancy = bs, alloc_ready = 0, alloc_index = 0 (don't-care value, fixed at 0).

Decomposition:
- Package esm_pkg: entry-state enum (FREE=0, WAIT=1, READY=2, ISSUED=3) and the IDX_W helper function, shared with the dependency-analysis stage.
- Sub-module esm_prio_enc (lowest-set-bit encoder, bs-wide, with valid output), used for alloc_index and the final one-hot→index of issue selection.

Test Plan:
1. Reset, then alloc 3 entries with alloc_dep=0, issue_ready=1 → issue order 0,1,2; after 3 completions occupancy returns to 0.
2. Alloc entry 0 (dep 0), entry 1 with alloc_dep=16'h0001 → entry 1 stays WAIT; complete 0 → issue_valid with issue_index=1 on the following cycle.
3. Fill 16 entries, issue_ready=0 → alloc_ready=0, occupancy=16; further alloc_valid ignored.
4. Complete entry 5, then alloc → new entry index 5 is youngest: with entries 3 and 5 both READY, issue_index=3.
5. Same edge: complete entry 2 and alloc with alloc_dep=16'h0004 → new entry enters READY, not WAIT.
6. Assert rst_n low mid-stream with 7 occupied entries → all outputs at reset values immediately, before the next clock edge. Separately, flush high for one cycle → occupancy=0 on the next edge.
